// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache: 2^INDEX_BITS lines of 4 words,
// zero-cycle combinational hit and a 4-beat refill FSM.
module instruction_cache #(
   parameter int unsigned INDEX_BITS = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instruction_address,
   output logic [31:0] instruction,
   output logic        hit,
   output logic        mem_read_request,
   output logic [31:0] mem_address,
   input  logic        mem_ready,
   input  logic [31:0] mem_data,
   output logic [15:0] miss_count
);

   localparam int unsigned LINES = 2 ** INDEX_BITS;
   localparam int unsigned TAG_W = 28 - INDEX_BITS;

   localparam logic [0:0] LOOKUP = 1'b0;
   localparam logic [0:0] REFILL = 1'b1;

   logic [0:0]            r_state;
   logic [1:0]            r_beat;
   logic [27:0]           r_block;
   logic                  r_req;
   logic [15:0]           r_miss_count;
   logic [LINES-1:0]      r_valid;
   logic [TAG_W-1:0]      r_tag  [LINES];
   logic [31:0]           r_data [LINES*4];

   logic [1:0]            w_offset;
   logic [INDEX_BITS-1:0] w_index;
   logic [TAG_W-1:0]      w_tag;
   logic [INDEX_BITS-1:0] w_refill_index;
   logic [TAG_W-1:0]      w_refill_tag;
   logic                  w_beat_we;
   logic                  w_last_beat;
   logic                  w_hit;
   logic                  w_unused;

   assign w_offset       = instruction_address[3:2];
   assign w_index        = instruction_address[3+INDEX_BITS:4];
   assign w_tag          = instruction_address[31:4+INDEX_BITS];
   assign w_unused       = ^instruction_address[1:0];

   // Refill targets the latched block, never the live PC.
   assign w_refill_index = r_block[INDEX_BITS-1:0];
   assign w_refill_tag   = r_block[27:INDEX_BITS];

   assign w_beat_we      = (r_state == REFILL) && mem_ready && !reset;
   assign w_last_beat    = w_beat_we && (r_beat == 2'd3);

   assign w_hit          = (r_state == LOOKUP) && r_valid[w_index]
                           && (r_tag[w_index] == w_tag);

   assign hit              = w_hit;
   assign instruction      = w_hit ? r_data[{w_index, w_offset}] : '0;
   assign mem_read_request = r_req;
   assign mem_address      = {r_block, 4'b0000};
   assign miss_count       = r_miss_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= LOOKUP;
         r_beat       <= '0;
         r_block      <= '0;
         r_req        <= 1'b0;
         r_miss_count <= '0;
         r_valid      <= '0;
      end else begin
         case (r_state)
            LOOKUP: begin
               if (!w_hit) begin
                  r_block      <= instruction_address[31:4];
                  r_req        <= 1'b1;
                  r_miss_count <= r_miss_count + 16'd1;
                  r_state      <= REFILL;
               end
            end
            default: begin
               if (mem_ready) begin
                  r_beat <= r_beat + 2'd1;
                  if (r_beat == 2'd0) begin
                     r_valid[w_refill_index] <= 1'b0;
                  end
                  if (r_beat == 2'd3) begin
                     r_valid[w_refill_index] <= 1'b1;
                     r_req                   <= 1'b0;
                     r_state                 <= LOOKUP;
                  end
               end
            end
         endcase
      end
   end

   // Data and tag storage carry no reset; the valid bits guard them.
   always_ff @(posedge clock) begin
      if (w_beat_we) begin
         r_data[{w_refill_index, r_beat}] <= mem_data;
      end
      if (w_last_beat) begin
         r_tag[w_refill_index] <= w_refill_tag;
      end
   end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache: cold miss, same-line
// hits, conflict eviction, gapped beats, PC change and reset mid-refill.
module tb_instruction_cache;

   logic        clock;
   logic        reset;
   logic [31:0] instruction_address;
   logic [31:0] instruction;
   logic        hit;
   logic        mem_read_request;
   logic [31:0] mem_address;
   logic        mem_ready;
   logic [31:0] mem_data;
   logic [15:0] miss_count;

   int unsigned checks;
   int unsigned failures;

   instruction_cache #(.INDEX_BITS(4)) dut (
      .clock               (clock),
      .reset               (reset),
      .instruction_address (instruction_address),
      .instruction         (instruction),
      .hit                 (hit),
      .mem_read_request    (mem_read_request),
      .mem_address         (mem_address),
      .mem_ready           (mem_ready),
      .mem_data            (mem_data),
      .miss_count          (miss_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Idle 'gap' cycles, then present one beat for exactly one edge.
   task automatic beat(input logic [31:0] data, input int unsigned gap);
      mem_ready = 1'b0;
      for (int unsigned i = 0; i < gap; i++) step();
      mem_ready = 1'b1;
      mem_data  = data;
      step();
      mem_ready = 1'b0;
      mem_data  = '0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      mem_ready = 1'b0;
      mem_data = '0;
      instruction_address = 32'h40;
      step();
      step();
      check("rst_req", {31'd0, mem_read_request}, 32'd0);
      check("rst_miss", {16'd0, miss_count}, 32'd0);
      check("rst_addr", mem_address, 32'd0);
      check("rst_hit", {31'd0, hit}, 32'd0);

      // Cold miss on 0x40
      reset = 1'b0;
      #1;
      check("cold_hit0", {31'd0, hit}, 32'd0);
      check("cold_instr0", instruction, 32'd0);
      step();
      check("cold_req", {31'd0, mem_read_request}, 32'd1);
      check("cold_addr", mem_address, 32'h40);
      check("cold_miss", {16'd0, miss_count}, 32'd1);
      beat(32'hA0, 0);
      beat(32'hA1, 0);
      beat(32'hA2, 0);
      check("cold_hit_partial", {31'd0, hit}, 32'd0);
      beat(32'hA3, 0);
      check("cold_hit1", {31'd0, hit}, 32'd1);
      check("cold_instr", instruction, 32'hA0);
      check("cold_req_done", {31'd0, mem_read_request}, 32'd0);

      // Same-line hits
      instruction_address = 32'h44; #1;
      check("hit44", {31'd0, hit}, 32'd1);
      check("instr44", instruction, 32'hA1);
      instruction_address = 32'h48; #1;
      check("instr48", instruction, 32'hA2);
      instruction_address = 32'h4F; #1;
      check("instr4f", instruction, 32'hA3);
      step();
      check("same_miss", {16'd0, miss_count}, 32'd1);
      check("same_req", {31'd0, mem_read_request}, 32'd0);

      // mem_ready while in LOOKUP has no effect
      mem_ready = 1'b1;
      mem_data = 32'hDEAD;
      step();
      mem_ready = 1'b0;
      check("lk_ready_miss", {16'd0, miss_count}, 32'd1);
      check("lk_ready_instr", instruction, 32'hA3);

      // Conflict eviction on index 4, with gapped beats
      instruction_address = 32'h140;
      step();
      check("conf_req", {31'd0, mem_read_request}, 32'd1);
      check("conf_addr", mem_address, 32'h140);
      check("conf_miss", {16'd0, miss_count}, 32'd2);
      beat(32'hB0, 2);
      check("gap_hit_b0", {31'd0, hit}, 32'd0);
      beat(32'hB1, 2);
      beat(32'hB2, 2);
      check("gap_hit_b2", {31'd0, hit}, 32'd0);
      check("gap_addr_stable", mem_address, 32'h140);
      beat(32'hB3, 2);
      check("gap_hit", {31'd0, hit}, 32'd1);
      check("gap_instr0", instruction, 32'hB0);
      instruction_address = 32'h14C; #1;
      check("gap_instr3", instruction, 32'hB3);

      // 0x40 was evicted
      instruction_address = 32'h40; #1;
      check("evict_hit", {31'd0, hit}, 32'd0);
      step();
      check("evict_miss", {16'd0, miss_count}, 32'd3);
      check("evict_addr", mem_address, 32'h40);

      // PC moves to 0x80 during the 0x40 refill
      beat(32'hC0, 0);
      instruction_address = 32'h80;
      beat(32'hC1, 1);
      check("pcchg_addr", mem_address, 32'h40);
      beat(32'hC2, 1);
      beat(32'hC3, 1);
      check("pcchg_hit", {31'd0, hit}, 32'd0);
      check("pcchg_req0", {31'd0, mem_read_request}, 32'd0);
      step();
      check("pcchg_req", {31'd0, mem_read_request}, 32'd1);
      check("pcchg_maddr", mem_address, 32'h80);
      check("pcchg_miss", {16'd0, miss_count}, 32'd4);
      beat(32'hD0, 0);
      beat(32'hD1, 0);
      beat(32'hD2, 0);
      beat(32'hD3, 0);
      check("d_instr", instruction, 32'hD0);
      instruction_address = 32'h48; #1;
      check("c_hit", {31'd0, hit}, 32'd1);
      check("c_instr", instruction, 32'hC2);

      // Reset mid-refill
      instruction_address = 32'h100;
      step();
      check("rm_miss", {16'd0, miss_count}, 32'd5);
      beat(32'hE0, 0);
      beat(32'hE1, 0);
      reset = 1'b1;
      instruction_address = 32'h40;
      step();
      check("rm_req", {31'd0, mem_read_request}, 32'd0);
      check("rm_count", {16'd0, miss_count}, 32'd0);
      check("rm_maddr", mem_address, 32'd0);
      reset = 1'b0;
      #1;
      check("rm_hit", {31'd0, hit}, 32'd0);
      step();
      check("rm_remiss_req", {31'd0, mem_read_request}, 32'd1);
      check("rm_remiss_cnt", {16'd0, miss_count}, 32'd1);
      check("rm_remiss_addr", mem_address, 32'h40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
